// File: rtl/hist_pkg.sv
// hist_pkg: shared state encoding, constants and width helper for the histogram-equalization engine.
package hist_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, HIST, CDF, MAP, DONE} state_t;
  localparam int NUM_BINS = 256;
  localparam int PIX_MAX = 255;
  function automatic int cdf_width(input int tpb);
    return tpb + 1;
  endfunction
endpackage

// File: rtl/hist_lut_calc.sv
// hist_lut_calc: running CDF accumulator and the 256-entry equalization LUT with a combinational read port.
module hist_lut_calc
  import hist_pkg::*;
#(
  parameter int TPB = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      en,
  input  logic [7:0]                idx,
  input  logic [cdf_width(TPB)-1:0] count,
  input  logic [7:0]                rd_idx,
  output logic [7:0]                rd_val
);
  localparam int CW = cdf_width(TPB);
  localparam int PW = 8 + CW;
  logic [CW-1:0] cdf, cdf_new;
  logic [PW-1:0] prod;
  logic [7:0] lut [NUM_BINS];
  always_comb begin
    cdf_new = cdf + count;
    prod = PW'(cdf_new) * PW'(PIX_MAX);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cdf <= '0;
      for (int i = 0; i < NUM_BINS; i++) lut[i] <= '0;
    end else if (clr) begin
      cdf <= '0;
    end else if (en) begin
      cdf <= cdf_new;
      lut[idx] <= 8'(prod >> TPB);
    end
  assign rd_val = lut[rd_idx];
endmodule

// File: rtl/hist_eq_core.sv
// hist_eq_core: two-pass histogram equalization of one frame (histogram build, CDF/LUT, remap to output RAM).
module hist_eq_core
  import hist_pkg::*;
#(
  parameter int W = 64,
  parameter int H = 64,
  parameter int TOTAL_PIXEL = W * H,
  parameter int TOTAL_PIXEL_BIT = $clog2(W * H)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [TOTAL_PIXEL_BIT-1:0] in_rd_addr,
  input  logic [7:0]                 in_rd_data,
  output logic                       wr_en,
  output logic [TOTAL_PIXEL_BIT-1:0] wr_addr,
  output logic [7:0]                 wr_data
);
  localparam int AW = TOTAL_PIXEL_BIT;
  localparam int CW = cdf_width(AW);
  localparam logic [AW:0] LAST = (AW+1)'(TOTAL_PIXEL);
  localparam logic [AW:0] MAP_END = (AW+1)'(TOTAL_PIXEL - 1);
  localparam logic [AW:0] CDF_LAST = (AW+1)'(NUM_BINS - 1);
  state_t state, state_n;
  logic [AW:0] cnt;
  logic issue, rd_vld, map_ld;
  logic [AW-1:0] addr_d;
  logic [CW-1:0] hist [NUM_BINS];
  logic [7:0] lut_val;
  // MAP prefetches address 0 in the final CDF cycle so writes fill MAP cycles 2..TOTAL_PIXEL+1
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = start ? CLEAR : IDLE;
      CLEAR:   state_n = HIST;
      HIST:    state_n = (cnt == LAST) ? CDF : HIST;
      CDF:     state_n = (cnt == CDF_LAST) ? MAP : CDF;
      MAP:     state_n = (cnt == LAST) ? DONE : MAP;
      default: state_n = IDLE;
    endcase
    issue = (state == HIST && cnt < LAST) || (state == CDF && cnt == CDF_LAST) ||
            (state == MAP && cnt < MAP_END);
    map_ld = rd_vld && state == MAP;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      in_rd_addr <= '0;
      rd_vld <= 1'b0;
      addr_d <= '0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      state <= state_n;
      cnt <= (state_n != state) ? '0 : cnt + 1'b1;
      in_rd_addr <= (state == CLEAR) ? '0 : in_rd_addr + AW'(issue);
      rd_vld <= issue;
      addr_d <= issue ? in_rd_addr : addr_d;
      wr_en <= map_ld;
      wr_addr <= map_ld ? addr_d : wr_addr;
      wr_data <= map_ld ? lut_val : wr_data;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst || state == CLEAR) begin
      for (int i = 0; i < NUM_BINS; i++) hist[i] <= '0;
    end else if (rd_vld && state == HIST) begin
      hist[in_rd_data] <= hist[in_rd_data] + 1'b1;
    end
  hist_lut_calc #(.TPB(AW)) u_lut (
    .clk(clk),
    .rst(rst),
    .clr(state == CLEAR),
    .en(state == CDF),
    .idx(cnt[7:0]),
    .count(hist[cnt[7:0]]),
    .rd_idx(in_rd_data),
    .rd_val(lut_val)
  );
  assign busy = state != IDLE;
  assign done = state == DONE;
endmodule

// File: doc/hist_eq_core.md
# hist_eq_core

Histogram-equalization engine for one W×H 8-bit grayscale frame. It reads every pixel of the input frame RAM twice: once to build the 256-bin histogram, once to remap pixels through the CDF-derived LUT. The remapped pixels are written into the output frame RAM (`ram_out`) through that RAM's `wr_en`/`wr_addr`/`wr_data` port. This block sits directly upstream of `ram_out` and is its only writer.

## Interface
- `W`, 64, frame width in pixels
- `H`, 64, frame height in pixels
- `TOTAL_PIXEL`, W*H, pixels per frame; must be a power of two
- `TOTAL_PIXEL_BIT`, $clog2(W*H), address width
- `clk` in 1: single clock, all logic rising-edge
- `rst` in 1: asynchronous, active-high reset
- `start` in 1: begin one frame; sampled only in IDLE
- `busy` out 1: high in every state except IDLE
- `done` out 1: one-cycle pulse when the last output pixel has been written
- `in_rd_addr` out TOTAL_PIXEL_BIT: input RAM read address
- `in_rd_data` in 8: input RAM data, valid one cycle after `in_rd_addr`
- `wr_en` out 1: output RAM write enable
- `wr_addr` out TOTAL_PIXEL_BIT: output RAM write address
- `wr_data` out 8: equalized pixel

## Operation
- FSM states: IDLE, CLEAR, HIST, CDF, MAP, DONE.
- IDLE → CLEAR on `start`=1. Otherwise stay in IDLE.
- CLEAR lasts 1 cycle. All 256 histogram registers are zeroed, and the address counter and CDF accumulator are cleared.
- HIST:
  - The address counter drives `in_rd_addr` = 0..TOTAL_PIXEL-1, one per cycle.
  - A valid bit, delayed one cycle, increments `hist[in_rd_data]`.
  - Histogram entries are registers with TOTAL_PIXEL_BIT+1 bits, so a count of TOTAL_PIXEL fits.
  - Back-to-back equal pixels must each count; there is no RMW hazard.
  - The state lasts TOTAL_PIXEL+1 cycles.
- CDF:
  - Index v = 0..255, one per cycle: `cdf = cdf + hist[v]`.
  - `lut[v] = (cdf_new * 255) >> TOTAL_PIXEL_BIT`, truncated. The product is 8+TOTAL_PIXEL_BIT+1 bits wide.
  - The state lasts 256 cycles.
- MAP:
  - The address counter drives `in_rd_addr` = 0..TOTAL_PIXEL-1 again.
  - One cycle after each read, the registered outputs load: `wr_en`=1, `wr_addr`=delayed address, `wr_data`=`lut[in_rd_data]`.
  - The state lasts TOTAL_PIXEL+1 cycles.
- DONE lasts 1 cycle with `done`=1, then returns to IDLE.
- `start` while busy is ignored. `start` held high in DONE does not restart until IDLE has been reached.
- The LUT and histogram are retained after DONE until the next CLEAR.

## Timing
- Reset values: `busy`=0, `done`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `in_rd_addr`=0; state = IDLE.
- Cycle numbering: cycle 1 is the first cycle after the edge that samples `start`.
  - Cycle 1: CLEAR.
  - Cycles 2..TOTAL_PIXEL+2: HIST.
  - Next 256 cycles: CDF.
  - Next TOTAL_PIXEL+1 cycles: MAP.
  - Cycle 2*TOTAL_PIXEL+260: `done`=1. With 64×64 that is cycle 8452.
- `wr_en` is high for exactly TOTAL_PIXEL consecutive cycles, addresses strictly 0..TOTAL_PIXEL-1, no gaps. Its first assertion is the second MAP cycle, and it is low in DONE.
- Read latency from `in_rd_addr` to `wr_*` registered: 2 edges.
- `in_rd_addr` holds its last value outside HIST/MAP. Its value is don't-care to the RAM.
- Reset asserted mid-frame clears everything asynchronously: `wr_en` drops immediately and the partial output frame is abandoned. A new `start` is required.

## Structure
- Shared package `hist_pkg`:
  - FSM state encoding.
  - Constants: `NUM_BINS`=256, `PIX_MAX`=255.
  - Function computing CDF width from TOTAL_PIXEL_BIT.
- One natural sub-module: `hist_lut_calc`, the CDF accumulator plus LUT register file.
  - Inputs: bin index and count.
  - Output: combinational `lut[index]` read.
- Everything else (FSM, counters, histogram array) lives in `hist_eq_core`.

## Test plan
- All 4096 pixels 0x80 → `hist[0x80]`=4096 and lut[0x80]=255. Output RAM contains 4096×0xFF, and `done` fires at cycle 8452.
- Ramp pixel i = i%256 → each bin is 16 and `lut[v]`=((v+1)*255)>>8. Output at address 0 is 0x00, at 127 is 0x7F, at 255 is 0xFF.
- First half 0x00, second half 0xFF → output is 2048×0x7F followed by 2048×0xFF.
- Reset asserted 100 cycles into MAP → `wr_en`/`busy` are 0 immediately. A fresh `start` then produces a complete, correct frame.
- `start` pulsed during HIST and held through DONE → no restart while busy and exactly one `done` per accepted start. `wr_en` count is exactly 4096 per frame, checked against `ram_out` readback.
